floor_req_gen: RTL and testbench

- Request initiator for the elevator controller. Conditions raw floor buttons, latches pending calls, and schedules the next target floor in SCAN order.
- Drives `req` into `ctrl_unit`. Consumes the controller's `floor`, `up`, `down` and `open` outputs as service feedback.
- Also drives the call lamps and a busy flag.

---
 rtl/elev_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 44 ++++
 rtl/floor_req_gen.sv | 156 +++++++++++++++
 tb/tb_floor_req_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator request path.
// Floor indices, scheduler state and request-word field positions.
package elev_pkg;

    localparam int MAX_FLOORS  = 16;
    localparam int REQ_TGT_LSB = 0;
    localparam int REQ_TGT_W   = 4;

    typedef logic [3:0] floor_t;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_UP,
        SERVE_DOWN
    } sched_state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

endpackage

// File: rtl/btn_debounce.sv
// One call button: 2-FF synchronizer, stability counter and a single-cycle
// press pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50
) (
    input  logic clk,
    input  logic resetN,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // The D-th consecutive differing sample is what commits the change.
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/floor_req_gen.sv
// Elevator request initiator: debounced call buttons, pending-call latch and
// a SCAN scheduler that picks the next target floor for the controller.
module floor_req_gen
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS      = 8,
    parameter int DEBOUNCE_CYCLES = 50
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [3:0]            floor,
    input  logic                  up,
    input  logic                  down,
    input  logic                  open,
    output logic [7:0]            req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    logic [NUM_FLOORS-1:0] level;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] pend_nxt;

    sched_state_e state;
    dir_e         dir;
    floor_t       tgt;

    logic   above;
    logic   below;
    logic   here;
    logic   ge_found;
    logic   le_found;
    floor_t ge_idx;
    floor_t le_idx;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .resetN (resetN),
            .btn_raw(btn[g]),
            .level  (level[g]),
            .press  (press[g])
        );
    end

    // Serving a floor beats a new press for it: the doors are already open.
    always_comb begin
        pend_nxt = pending | press;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (open && (i == int'(floor))) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pending <= '0;
            busy    <= 1'b0;
        end else begin
            pending <= pend_nxt;
            busy    <= |pend_nxt;
        end
    end

    // Floors outside the shaft never match any index, so nothing is "here".
    always_comb begin
        above    = 1'b0;
        below    = 1'b0;
        here     = 1'b0;
        le_found = 1'b0;
        le_idx   = '0;
        ge_found = 1'b0;
        ge_idx   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (i > int'(floor)) above = 1'b1;
                if (i < int'(floor)) below = 1'b1;
                if (i == int'(floor)) here = 1'b1;
                if (i <= int'(floor)) begin
                    le_found = 1'b1;
                    le_idx   = floor_t'(i);
                end
            end
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i >= int'(floor))) begin
                ge_found = 1'b1;
                ge_idx   = floor_t'(i);
            end
        end
    end

    // Door dwell freezes both the state and the target.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
            dir   <= DIR_UP;
            tgt   <= '0;
        end else if (!open) begin
            case (state)
                IDLE: begin
                    if (above && !(below && down)) begin
                        state <= SERVE_UP;
                        dir   <= DIR_UP;
                        tgt   <= ge_idx;
                    end else if (below) begin
                        state <= SERVE_DOWN;
                        dir   <= DIR_DOWN;
                        tgt   <= le_idx;
                    end else if (here) begin
                        state <= SERVE_UP;
                        dir   <= DIR_UP;
                        tgt   <= floor;
                    end
                end
                SERVE_UP: begin
                    if (ge_found) begin
                        tgt <= ge_idx;
                    end else if (below) begin
                        state <= SERVE_DOWN;
                        dir   <= DIR_DOWN;
                        tgt   <= le_idx;
                    end else begin
                        state <= IDLE;
                    end
                end
                SERVE_DOWN: begin
                    if (le_found) begin
                        tgt <= le_idx;
                    end else if (above) begin
                        state <= SERVE_UP;
                        dir   <= DIR_UP;
                        tgt   <= ge_idx;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req = '0;
        req[REQ_TGT_LSB +: REQ_TGT_W] = tgt;
    end

    // Direction and accepted levels are kept as probe points; up is redundant with down.
    logic unused_taps;
    assign unused_taps = ^{up, level, dir};

endmodule

// File: tb/tb_floor_req_gen.sv
// Bench for floor_req_gen: directed scenarios plus random traffic, checked
// every cycle against a behavioural model through an expected-output queue.
module tb_floor_req_gen;

  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         resetN;
  logic [N-1:0] btn;
  logic [3:0]   floor;
  logic         up;
  logic         down;
  logic         open;
  logic [7:0]   req;
  logic [N-1:0] pending;
  logic         busy;

  always #5 clk = ~clk;

  floor_req_gen #(
    .NUM_FLOORS(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .btn(btn),
    .floor(floor),
    .up(up),
    .down(down),
    .open(open),
    .req(req),
    .pending(pending),
    .busy(busy)
  );

  // ---------------- reference model ----------------
  logic [31:0]  hist [N];   // raw button samples, bit j = sample j edges ago
  logic [N-1:0] acc_m;
  logic [N-1:0] press_m;
  logic [N-1:0] pend_m;
  logic         busy_m;
  int           mode_m;     // 0 idle, 1 sweeping up, 2 sweeping down
  logic [3:0]   tgt_m;
  logic [16:0]  exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  // lowest pending floor >= f (go_up) or highest pending floor <= f; -1 if none
  function automatic int nearest(logic [N-1:0] p, int f, bit go_up);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        if (go_up && i >= f && r < 0) r = i;
        if (!go_up && i <= f) r = i;
      end
    end
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] pn;
    int f, lo, hi, hi_all, lo_all;
    bit above, below, here, flip;
    if (!resetN) begin
      for (int i = 0; i < N; i++) hist[i] = '0;
      acc_m = '0; press_m = '0; pend_m = '0; busy_m = 1'b0;
      mode_m = 0; tgt_m = 4'h0;
    end else begin
      f      = int'(floor);
      hi_all = nearest(pend_m, 99, 1'b0);
      lo_all = nearest(pend_m, 0, 1'b1);
      above  = hi_all > f;
      below  = (lo_all >= 0) && (lo_all < f);
      here   = (f < N) && pend_m[f];
      lo     = nearest(pend_m, f, 1'b1);
      hi     = nearest(pend_m, f, 1'b0);
      if (!open) begin
        case (mode_m)
          0: begin
            if (above && !(below && down)) begin mode_m = 1; tgt_m = lo[3:0]; end
            else if (below) begin mode_m = 2; tgt_m = hi[3:0]; end
            else if (here) begin mode_m = 1; tgt_m = floor; end
          end
          1: begin
            if (lo >= 0) tgt_m = lo[3:0];
            else if (below) begin mode_m = 2; tgt_m = hi[3:0]; end
            else mode_m = 0;
          end
          default: begin
            if (hi >= 0) tgt_m = hi[3:0];
            else if (above) begin mode_m = 1; tgt_m = lo[3:0]; end
            else mode_m = 0;
          end
        endcase
      end
      pn = pend_m | press_m;
      if (open && f < N) pn[f] = 1'b0;
      pend_m = pn;
      busy_m = |pn;
      // a level is accepted once D consecutive synchronized samples disagree with it
      for (int i = 0; i < N; i++) begin
        hist[i] = {hist[i][30:0], btn[i]};
        flip = 1'b1;
        for (int j = 2; j <= D + 1; j++) begin
          if (hist[i][j] == acc_m[i]) flip = 1'b0;
        end
        press_m[i] = flip && !acc_m[i];
        if (flip) acc_m[i] = ~acc_m[i];
      end
    end
    exp_q.push_back({busy_m, pend_m, 4'h0, tgt_m});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [16:0] mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        vectors++;
        if ({busy, pending, req} !== mon_e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t req=%h exp=%h pending=%h exp=%h busy=%b exp=%b",
                   $time, req, mon_e[7:0], pending, mon_e[15:8], busy, mon_e[16]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic b, logic [7:0] p, logic [7:0] r);
    vectors++;
    if (busy !== b || pending !== p || req !== r) begin
      miscompares++;
      $display("FAIL %s: busy=%b pending=%h req=%h, expected busy=%b pending=%h req=%h",
               name, busy, pending, req, b, p, r);
    end
  endtask

  task automatic press(int i);
    btn[i] = 1'b1;
    repeat (8) cycle();
    btn[i] = 1'b0;
    repeat (8) cycle();
  endtask

  task automatic serve(logic [3:0] f);
    floor = f;
    open  = 1'b1;
    repeat (2) cycle();
    open  = 1'b0;
    repeat (2) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx, r;
    resetN = 1'b0; btn = '1; floor = 4'd0; up = 1'b0; down = 1'b0; open = 1'b0;
    repeat (4) begin
      cycle();
      chk("reset_state", 1'b0, 8'h00, 8'h00);
    end
    resetN = 1'b1;
    repeat (3) cycle();
    btn = '0;
    repeat (8) cycle();
    chk("reset_debounce_restart", 1'b0, 8'h00, 8'h00);

    // debounce
    btn[4] = 1'b1; repeat (3) cycle(); btn[4] = 1'b0;
    repeat (8) cycle();
    chk("glitch_rejected", 1'b0, 8'h00, 8'h00);
    btn[4] = 1'b1;
    repeat (6) cycle();
    chk("press_latency_early", 1'b0, 8'h00, 8'h00);
    cycle();
    chk("press_latency", 1'b1, 8'h10, 8'h00);
    cycle();
    chk("first_req", 1'b1, 8'h10, 8'h04);
    repeat (2) cycle();
    btn[4] = 1'b0;
    repeat (8) cycle();
    chk("hold_one_pulse", 1'b1, 8'h10, 8'h04);
    serve(4'd4);
    chk("served_idle_hold", 1'b0, 8'h00, 8'h04);

    // SCAN ordering from floor 2
    floor = 4'd2;
    press(6); chk("scan_first", 1'b1, 8'h40, 8'h06);
    press(1); chk("scan_behind_deferred", 1'b1, 8'h42, 8'h06);
    press(4); chk("scan_insert", 1'b1, 8'h52, 8'h04);
    serve(4'd4); chk("scan_after4", 1'b1, 8'h42, 8'h06);
    serve(4'd6); chk("scan_reverse", 1'b1, 8'h02, 8'h01);
    serve(4'd1); chk("scan_done", 1'b0, 8'h00, 8'h01);

    // insertion ahead at floor 3
    floor = 4'd3;
    press(6); press(2);
    chk("insert_deferred", 1'b1, 8'h44, 8'h06);
    btn[5] = 1'b1;
    repeat (7) cycle();
    chk("insert_pending", 1'b1, 8'h64, 8'h06);
    cycle();
    chk("insert_retarget", 1'b1, 8'h64, 8'h05);
    repeat (3) cycle(); btn[5] = 1'b0; repeat (6) cycle();
    serve(4'd5); serve(4'd6); serve(4'd2);
    chk("insert_cleanup", 1'b0, 8'h00, 8'h02);

    // same-cycle set and clear at floor 3
    floor = 4'd3;
    btn[3] = 1'b1;
    repeat (6) cycle();
    open = 1'b1; cycle(); open = 1'b0;
    chk("set_clear_same_cycle", 1'b0, 8'h00, 8'h02);
    repeat (4) cycle(); btn[3] = 1'b0; repeat (8) cycle();
    chk("set_clear_no_repress", 1'b0, 8'h00, 8'h02);

    // reset mid-operation
    floor = 4'd5; down = 1'b1;
    btn = 8'h82;
    repeat (8) cycle();
    chk("tie_serve_down", 1'b1, 8'h82, 8'h01);
    btn = '0;
    resetN = 1'b0; cycle(); resetN = 1'b1;
    chk("mid_reset", 1'b0, 8'h00, 8'h00);
    down = 1'b0; floor = 4'd9; open = 1'b1;
    press(2);
    chk("floor_out_of_range", 1'b1, 8'h04, 8'h00);
    open = 1'b0; cycle();
    chk("out_of_range_schedule", 1'b1, 8'h04, 8'h02);
    serve(4'd2);

    // random traffic
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        btn[idx] = ~btn[idx];
      end
      if ($urandom_range(0, 7) == 0) floor = 4'($urandom_range(0, 9));
      open = ($urandom_range(0, 4) == 0);
      r = int'($urandom_range(0, 2));
      up = (r == 1);
      down = (r == 2);
      resetN = ($urandom_range(0, 199) != 0);
      cycle();
    end
    resetN = 1'b1; open = 1'b0;
    cycle();

    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
